blink_ctrl: RTL and testbench
=============================

BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: on-window length in ticks for BURST mode; even, >=2.
REQ-002 SHALL have port clk  input  1  system clock; sole clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clk_divider  input  1  slow square wave from the upstream clock divider; asynchronous to clk.
REQ-005 SHALL have port mode  input  2  LED mode: 00 OFF, 01 BLINK, 10 SOLID, 11 BURST.
REQ-006 SHALL have port led  output  1  LED drive, active-high.
REQ-007 SHALL have port tick  output  1  registered one-cycle pulse per clk_divider rising edge.
REQ-008 SHALL have port tick_count  output  8  running count of ticks.

Function
REQ-009 SHALL pass clk_divider through a 2-flop synchronizer, then a rising-edge detector.
REQ-010 SHALL assert tick for exactly one clk cycle, on the 3rd clk rising edge after the first edge that samples clk_divider high.
REQ-011 SHALL produce exactly one tick per clk_divider rising edge, however long clk_divider stays high.
REQ-012 SHALL update led, tick_count and internal state only on the clk edge that asserts tick; otherwise all hold.
REQ-013 SHALL sample mode only at ticks; mode changes between ticks take effect at the next tick.
REQ-014 SHALL implement FSM states S_OFF, S_BLINK, S_SOLID, S_BURST, selected by the mode sampled at each tick.
REQ-015 SHALL, when a tick samples a mode that differs from the current state, enter the new state with led=1 for BLINK/SOLID/BURST, led=0 for OFF, and burst phase p=0.
REQ-016 SHALL, on a tick with unchanged mode: S_OFF led=0; S_SOLID led=1; S_BLINK led toggles.
REQ-017 SHALL, in S_BURST, advance p modulo 2*BURST_LEN on each tick with unchanged mode, and drive led=1 iff p<BURST_LEN and p is even.
REQ-018 SHALL size p at $clog2(2*BURST_LEN) bits.
REQ-019 SHALL increment tick_count on every tick, wrapping 255->0.

Reset
REQ-020 SHALL, while reset=1, asynchronously force led=0, tick=0, tick_count=0, p=0, synchronizer and edge flops=0, state=S_OFF.
REQ-021 SHALL treat a clk_divider high level at reset deassertion as a rising edge, giving one tick per REQ-010.
REQ-022 SHALL, on reset mid-burst or mid-blink, discard phase; the next tick enters the sampled mode per REQ-015.

Configuration
REQ-023 SHALL compile the tick_count counter only when macro BLINK_TICK_COUNT_EN is defined.
REQ-024 SHALL, without BLINK_TICK_COUNT_EN, keep the tick_count port and tie it to 8'd0; led and tick behaviour are unchanged.

Structure
REQ-025 SHALL place the mode encoding typedef (MODE_OFF, MODE_BLINK, MODE_SOLID, MODE_BURST), the FSM state enum and the BURST_LEN default constant in package blink_pkg.
REQ-026 SHALL place the synchronizer and edge detector in sub-module sync_edge (in: clk, reset, async_in; out: rise_pulse).

Verification
(clk period 10 ns; clk_divider period 200 ns in simulation)
REQ-027 SHALL check: reset=1 for 22 ns, then released with clk_divider=0 -> led=0, tick=0, tick_count=0 until the first clk_divider rise.
REQ-028 SHALL check: mode=01, clk_divider rises at t -> tick high for exactly one cycle on the 3rd clk edge after t; led toggles 1,0,1,0 over 4 ticks.
REQ-029 SHALL check: mode=11, BURST_LEN=4 -> led over ticks 0..8 = 1,0,1,0,0,0,0,0,1.
REQ-030 SHALL check: mode changes 01->10 mid-period -> led unchanged until the next tick, then led=1 and held.
REQ-031 SHALL check: 256 ticks -> tick_count wraps to 0; without BLINK_TICK_COUNT_EN, tick_count=0 throughout.
REQ-032 SHALL check: reset pulsed mid-burst -> outputs 0 immediately; clk_divider held high for 1000 ns -> exactly one tick.

Source files
------------

// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blink_pkg
// Brief    : Shared types and constants for the blink_ctrl LED controller:
//            mode encoding, FSM state encoding, default burst length and a
//            helper mapping a sampled mode onto its FSM state.
// Revision : 1.0 - initial release
// ============================================================================
package blink_pkg;

  // Encoding of the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_SOLID = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  // LED controller FSM states, one per mode.
  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_BLINK = 2'b01,
    S_SOLID = 2'b10,
    S_BURST = 2'b11
  } state_t;

  // Default on-window length (in ticks) of BURST mode.
  localparam int c_burst_len_default = 4;

  // State the FSM should occupy for a given sampled mode.
  function automatic state_t mode_to_state(input mode_t m);
    state_t s;
    case (m)
      MODE_BLINK: s = S_BLINK;
      MODE_SOLID: s = S_SOLID;
      MODE_BURST: s = S_BURST;
      default:    s = S_OFF;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Brings an asynchronous level into the clk domain through a
//            2-flop synchronizer and emits a registered one-cycle pulse on
//            each synchronized rising edge.  The pulse rises on the 2nd clk
//            edge after the first edge that samples async_in high.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;

  // Two-stage synchronizer; r_sync1 may go metastable, r_sync2 is clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
    end
  end

  // Edge detector: remember the last synchronized level and register the
  // low-to-high transition.  Because the history flop resets to 0, a level
  // already high at reset release is reported as a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      r_rise <= r_sync2 & ~r_prev;
    end
  end

  assign rise_pulse = r_rise;

endmodule
`default_nettype wire

// File: rtl/blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blink_ctrl
// Brief    : LED controller paced by a slow external divider.  Each rising
//            edge of clk_divider becomes one registered tick; on each tick the
//            FSM samples mode and updates the LED (OFF / BLINK / SOLID /
//            BURST).  Between ticks every output and all state hold.
// Config   : BLINK_TICK_COUNT_EN - when defined, tick_count is an 8-bit
//            wrapping tick counter; otherwise the port is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module blink_ctrl
  import blink_pkg::*;
#(
  parameter int BURST_LEN = c_burst_len_default
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_divider,
  input  logic [1:0] mode,
  output logic       led,
  output logic       tick,
  output logic [7:0] tick_count
);

  // Burst phase runs over one on-window plus one off-window.
  localparam int c_period = 2 * BURST_LEN;
  localparam int c_p_w    = $clog2(c_period);
  localparam logic [c_p_w-1:0] c_p_last = c_p_w'(c_period - 1);
  localparam logic [c_p_w-1:0] c_on_len = c_p_w'(BURST_LEN);

  logic             w_rise;
  state_t           w_sampled;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_led;
  logic             w_led_nxt;
  logic [c_p_w-1:0] r_p;
  logic [c_p_w-1:0] w_p_nxt;
  logic             r_tick;

  sync_edge u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .async_in   (clk_divider),
    .rise_pulse (w_rise)
  );

  // FSM state, LED and burst phase registers; the tick is the rise pulse
  // delayed by one cycle so it lands on the same edge as the LED update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_OFF;
      r_led   <= 1'b0;
      r_p     <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_p     <= w_p_nxt;
      r_tick  <= w_rise;
    end
  end

  // Next-state logic: everything holds unless this edge is a tick.  A tick
  // whose mode differs from the current state restarts in the new state;
  // otherwise the current state advances its own LED pattern.
  always_comb begin
    w_sampled   = mode_to_state(mode_t'(mode));
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_p_nxt     = r_p;
    if (w_rise) begin
      if (w_sampled != r_state) begin
        w_state_nxt = w_sampled;
        w_led_nxt   = (w_sampled != S_OFF);
        w_p_nxt     = '0;
      end else begin
        case (r_state)
          S_OFF:   w_led_nxt = 1'b0;
          S_SOLID: w_led_nxt = 1'b1;
          S_BLINK: w_led_nxt = ~r_led;
          S_BURST: begin
            w_p_nxt   = (r_p == c_p_last) ? '0 : r_p + c_p_w'(1);
            // Pulses on even phases inside the on-window only.
            w_led_nxt = (w_p_nxt < c_on_len) && !w_p_nxt[0];
          end
          default: w_led_nxt = 1'b0;
        endcase
      end
    end
  end

  assign led  = r_led;
  assign tick = r_tick;

`ifdef BLINK_TICK_COUNT_EN
  logic [7:0] r_tick_count;

  // Running tick counter, wraps from 255 to 0 by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_count <= 8'd0;
    end else if (w_rise) begin
      r_tick_count <= r_tick_count + 8'd1;
    end
  end

  assign tick_count = r_tick_count;
`else
  assign tick_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_blink_ctrl
// Brief    : Self-checking bench for blink_ctrl.  Each clk_divider rise
//            pushes the expected tick (cycle, led, tick_count) onto a
//            scoreboard; a monitor pops and compares when tick appears and
//            checks that outputs hold between ticks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blink_ctrl;

  localparam int c_bl = 4;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       clk_divider = 1'b0;
  logic [1:0] mode        = 2'b00;
  logic       led;
  logic       tick;
  logic [7:0] tick_count;

  blink_ctrl #(.BURST_LEN(c_bl)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .clk_divider (clk_divider),
    .mode        (mode),
    .led         (led),
    .tick        (tick),
    .tick_count  (tick_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       led;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic       tick_log[$];
  int         n_tests    = 0;
  int         n_fail     = 0;
  int         cyc        = 0;
  int         tick_total = 0;
  bit         chk_en     = 1'b0;
  logic       cur_led    = 1'b0;
  logic [7:0] cur_cnt    = 8'd0;

  // Reference model of the controller, advanced once per expected tick.
  logic [1:0] m_state = 2'b00;
  logic       m_led   = 1'b0;
  int         m_p     = 0;
  logic [7:0] m_cnt   = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_tick();
    if (mode != m_state) begin
      m_state = mode;
      m_led   = (mode != 2'b00);
      m_p     = 0;
    end else begin
      case (m_state)
        2'b00:   m_led = 1'b0;
        2'b10:   m_led = 1'b1;
        2'b01:   m_led = ~m_led;
        default: begin
          m_p   = (m_p + 1) % (2 * c_bl);
          m_led = (m_p < c_bl) && ((m_p % 2) == 0);
        end
      endcase
    end
`ifdef BLINK_TICK_COUNT_EN
    m_cnt = m_cnt + 8'd1;
`endif
  endtask

  task automatic model_reset();
    m_state = 2'b00;
    m_led   = 1'b0;
    m_p     = 0;
    m_cnt   = 8'd0;
    cur_led = 1'b0;
    cur_cnt = 8'd0;
    sb.delete();
  endtask

  // Called at the negedge where clk_divider is first seen high: the next
  // posedge samples it, and tick must appear three edges after that one.
  task automatic push_rise();
    exp_t e;
    model_tick();
    e.cyc = cyc + 4;
    e.led = m_led;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic div_rise(input int hi);
    @(negedge clk);
    clk_divider = 1'b1;
    push_rise();
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic div_fall(input int lo);
    @(negedge clk);
    clk_divider = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic div_period(input int hi, input int lo);
    div_rise(hi);
    div_fall(lo);
  endtask

  function automatic logic [31:0] log_bits(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v[i] = (i < tick_log.size()) ? tick_log[i] : 1'bx;
    return v;
  endfunction

  // Monitor: sample 1 ns after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (chk_en) begin
      if (tick === 1'b1) begin
        tick_total++;
        tick_log.push_back(led);
        if (sb.size() == 0) begin
          chk("tick_spurious", 32'(1), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("tick_cycle", cyc, mon_e.cyc);
          chk("tick_led", 32'(led), 32'(mon_e.led));
          chk("tick_count", 32'(tick_count), 32'(mon_e.cnt));
          cur_led = mon_e.led;
          cur_cnt = mon_e.cnt;
        end
      end else begin
        chk("tick_low", 32'(tick), 32'(0));
        if (sb.size() != 0 && cyc >= sb[0].cyc) begin
          chk("tick_missing", 32'(0), 32'(1));
          mon_e   = sb.pop_front();
          cur_led = mon_e.led;
          cur_cnt = mon_e.cnt;
        end else begin
          chk("led_hold", 32'(led), 32'(cur_led));
          chk("cnt_hold", 32'(tick_count), 32'(cur_cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  burst_exp;
    logic [3:0]  blink_exp;
    logic [7:0]  cnt_start;
    int          ticks_start;

    burst_exp = 9'b1_0000_0101;
    blink_exp = 4'b0101;

    // Reset held for 22 ns with the divider low.
    #22;
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_led", 32'(led), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_cnt", 32'(tick_count), 32'(0));

    // BLINK from OFF: 1,0,1,0.
    mode = 2'b01;
    tick_log.delete();
    repeat (4) div_period(10, 10);
    chk("blink_n", tick_log.size(), 4);
    chk("blink_seq", log_bits(4), 32'(blink_exp));

    // BURST from BLINK: 1,0,1,0,0,0,0,0,1.
    mode = 2'b11;
    tick_log.delete();
    repeat (9) div_period(10, 10);
    chk("burst_n", tick_log.size(), 9);
    chk("burst_seq", log_bits(9), 32'(burst_exp));

    // BLINK then a mid-period switch to SOLID: led holds until next tick.
    mode = 2'b01;
    div_period(10, 10);
    div_rise(10);
    chk("blink_off_phase", 32'(led), 32'(0));
    mode = 2'b10;
    div_fall(10);
    chk("solid_pending", 32'(led), 32'(0));
    repeat (3) div_period(10, 10);
    chk("solid_held", 32'(led), 32'(1));

    // OFF.
    mode = 2'b00;
    repeat (2) div_period(10, 10);
    chk("off_led", 32'(led), 32'(0));

    // 256 fast ticks: the counter returns to its starting value.
    mode      = 2'b01;
    cnt_start = m_cnt;
    repeat (256) div_period(4, 4);
    chk("wrap_cnt", 32'(tick_count), 32'(cnt_start));

    // Mid-burst asynchronous reset, then divider held high 1000 ns.
    mode = 2'b11;
    repeat (3) div_period(10, 10);
    chk("burst_pre_rst", 32'(led), 32'(1));
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'(0));
    chk("async_rst_tick", 32'(tick), 32'(0));
    chk("async_rst_cnt", 32'(tick_count), 32'(0));
    model_reset();
    clk_divider = 1'b1;
    repeat (3) @(negedge clk);
    reset       = 1'b0;
    chk_en      = 1'b1;
    ticks_start = tick_total;
    push_rise();
    repeat (97) @(negedge clk);
    chk("held_high_ticks", tick_total - ticks_start, 1);
    chk("post_rst_burst_led", 32'(led), 32'(1));
    div_fall(10);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
